// File: rtl/avalon_flash_master_if.sv
// Avalon-MM link between avalon_flash_master and the flash controller's slave register port.
interface avalon_flash_master_if;
  logic [3:0]  avl_mm_master_addr_o;
  logic [15:0] avl_mm_master_data_o;
  logic        avl_mm_master_write_o;
  logic        avl_mm_master_read_o;
  logic        avl_mm_master_byteenable_o;
  logic        avl_mm_master_waitrequest_i;
  logic [15:0] avl_mm_master_readdata_i;
  logic [1:0]  avl_mm_master_IRQ_i;

  modport master (
    output avl_mm_master_addr_o, avl_mm_master_data_o, avl_mm_master_write_o,
           avl_mm_master_read_o, avl_mm_master_byteenable_o,
    input  avl_mm_master_waitrequest_i, avl_mm_master_readdata_i, avl_mm_master_IRQ_i
  );

  modport slave (
    input  avl_mm_master_addr_o, avl_mm_master_data_o, avl_mm_master_write_o,
           avl_mm_master_read_o, avl_mm_master_byteenable_o,
    output avl_mm_master_waitrequest_i, avl_mm_master_readdata_i, avl_mm_master_IRQ_i
  );
endinterface

// File: rtl/avalon_flash_master.sv
// Sequences one flash command (block/other/TX/command writes, optional RX read) onto Avalon-MM.
// Optional FLASH_MASTER_STATUS_POLL_EN: poll the status register until flash ready before done.
module avalon_flash_master #(
  parameter int READ_LATENCY   = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        usr_req_i,
  output logic        usr_ready_o,
  input  logic [6:0]  usr_block_addr_i,
  input  logic        usr_lsb_i,
  input  logic [15:0] usr_other_addr_i,
  input  logic [15:0] usr_wdata_i,
  input  logic [3:0]  usr_code_i,
  input  logic        usr_rd_i,
  input  logic        usr_x16_i,
  output logic        usr_done_o,
  output logic        usr_err_o,
  output logic [15:0] usr_rdata_o,
  output logic [1:0]  usr_irq_o,
  avalon_flash_master_if.master avl
);
  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_WR_BLK   = 4'd1;
  localparam logic [3:0] S_WR_OTH   = 4'd2;
  localparam logic [3:0] S_WR_TX    = 4'd3;
  localparam logic [3:0] S_WR_CMD   = 4'd4;
  localparam logic [3:0] S_GAP      = 4'd5;
  localparam logic [3:0] S_RD_ISSUE = 4'd6;
  localparam logic [3:0] S_RD_WAIT  = 4'd7;
  localparam logic [3:0] S_DONE     = 4'd8;
`ifdef FLASH_MASTER_STATUS_POLL_EN
  localparam logic [3:0] S_POLL_RD   = 4'd9;
  localparam logic [3:0] S_POLL_WAIT = 4'd10;
`endif

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int LAT_W = $clog2(READ_LATENCY) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 1);

  logic [3:0]       state_q, state_nx, ret_q, ret_nx;
  logic [15:0]      oth_q, wd_q, data_q, rdata_q;
  logic [3:0]       code_q, addr_q;
  logic             rd_q, x16_q, err_q;
  logic [1:0]       irq_q;
  logic [TMO_W-1:0] tmo_q;
  logic [LAT_W-1:0] lat_q;
  logic             wr_act, rd_act, strobe, accept, tmo_hit, accept_req, lat_last, abort;

  // GAP always precedes a strobe state, so it is where the next offset/data get loaded.
  function automatic logic [3:0] reg_offset(input logic [3:0] st);
    case (st)
      S_WR_BLK:    reg_offset = 4'd1;
      S_WR_OTH:    reg_offset = 4'd2;
      S_WR_TX:     reg_offset = 4'd3;
      S_WR_CMD:    reg_offset = 4'd6;
      S_RD_ISSUE:  reg_offset = 4'd4;
`ifdef FLASH_MASTER_STATUS_POLL_EN
      S_POLL_RD:   reg_offset = 4'd5;
`endif
      default:     reg_offset = 4'd0;
    endcase
  endfunction

  function automatic logic [15:0] wr_word(input logic [3:0] st);
    case (st)
      S_WR_OTH: wr_word = oth_q;
      S_WR_TX:  wr_word = wd_q;
      S_WR_CMD: wr_word = {12'h000, code_q};
      default:  wr_word = data_q;
    endcase
  endfunction

  assign wr_act     = (state_q == S_WR_BLK) || (state_q == S_WR_OTH) ||
                      (state_q == S_WR_TX)  || (state_q == S_WR_CMD);
`ifdef FLASH_MASTER_STATUS_POLL_EN
  assign rd_act     = (state_q == S_RD_ISSUE) || (state_q == S_POLL_RD);
  assign lat_last   = ((state_q == S_RD_WAIT) || (state_q == S_POLL_WAIT)) && (lat_q == LAT_LAST);
`else
  assign rd_act     = (state_q == S_RD_ISSUE);
  assign lat_last   = (state_q == S_RD_WAIT) && (lat_q == LAT_LAST);
`endif
  assign strobe     = wr_act || rd_act;
  assign accept     = strobe && !avl.avl_mm_master_waitrequest_i;
  assign tmo_hit    = strobe && avl.avl_mm_master_waitrequest_i && (tmo_q == TMO_LAST);
  assign accept_req = (state_q == S_IDLE) && usr_req_i;

`ifdef FLASH_MASTER_STATUS_POLL_EN
  logic [TMO_W-1:0] poll_q;
  logic             poll_busy, poll_abort;
  assign poll_busy  = (state_q == S_POLL_WAIT) && lat_last && !avl.avl_mm_master_readdata_i[0];
  assign poll_abort = poll_busy && (poll_q == TMO_LAST);
  assign abort      = tmo_hit || poll_abort;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)          poll_q <= '0;
    else if (accept_req) poll_q <= '0;
    else if (poll_busy)  poll_q <= poll_q + TMO_W'(1);
  end
`else
  assign abort = tmo_hit;
`endif

  always_comb begin
    state_nx = state_q;
    ret_nx   = ret_q;
    case (state_q)
      S_IDLE:   if (usr_req_i) state_nx = S_WR_BLK;
      S_WR_BLK: if (accept) begin state_nx = S_GAP; ret_nx = S_WR_OTH; end
      S_WR_OTH: if (accept) begin state_nx = S_GAP; ret_nx = S_WR_TX;  end
      S_WR_TX:  if (accept) begin state_nx = S_GAP; ret_nx = S_WR_CMD; end
      S_WR_CMD: if (accept) begin
        if (rd_q) begin
          state_nx = S_GAP;
          ret_nx   = S_RD_ISSUE;
        end else begin
`ifdef FLASH_MASTER_STATUS_POLL_EN
          state_nx = S_GAP;
          ret_nx   = S_POLL_RD;
`else
          state_nx = S_DONE;
`endif
        end
      end
      S_GAP:      state_nx = ret_q;
      S_RD_ISSUE: if (accept) state_nx = S_RD_WAIT;
      S_RD_WAIT:  if (lat_last) begin
`ifdef FLASH_MASTER_STATUS_POLL_EN
        state_nx = S_GAP;
        ret_nx   = S_POLL_RD;
`else
        state_nx = S_DONE;
`endif
      end
`ifdef FLASH_MASTER_STATUS_POLL_EN
      S_POLL_RD:   if (accept) state_nx = S_POLL_WAIT;
      S_POLL_WAIT: if (lat_last) begin
        if (avl.avl_mm_master_readdata_i[0] || poll_abort) state_nx = S_DONE;
        else begin
          state_nx = S_GAP;
          ret_nx   = S_POLL_RD;
        end
      end
`endif
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (tmo_hit) state_nx = S_DONE;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      ret_q   <= S_IDLE;
      oth_q   <= '0;
      wd_q    <= '0;
      code_q  <= '0;
      rd_q    <= 1'b0;
      x16_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      tmo_q   <= '0;
      lat_q   <= '0;
      err_q   <= 1'b0;
      irq_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_nx;
      ret_q   <= ret_nx;
      tmo_q   <= (strobe && avl.avl_mm_master_waitrequest_i) ? tmo_q + TMO_W'(1) : '0;
      lat_q   <= (((state_q == S_RD_WAIT)
`ifdef FLASH_MASTER_STATUS_POLL_EN
                   || (state_q == S_POLL_WAIT)
`endif
                  ) && !lat_last) ? lat_q + LAT_W'(1) : '0;
      if (accept_req) begin
        oth_q  <= usr_other_addr_i;
        wd_q   <= usr_wdata_i;
        code_q <= usr_code_i;
        rd_q   <= usr_rd_i;
        x16_q  <= usr_x16_i;
        addr_q <= 4'd1;
        data_q <= {8'h00, usr_block_addr_i, usr_lsb_i};
        irq_q  <= '0;
        err_q  <= 1'b0;
      end else begin
        if (state_q == S_GAP) begin
          addr_q <= reg_offset(ret_q);
          data_q <= wr_word(ret_q);
        end
        if ((state_q != S_IDLE) && (avl.avl_mm_master_IRQ_i != 2'b00)) begin
          irq_q <= avl.avl_mm_master_IRQ_i;
          if (avl.avl_mm_master_IRQ_i[1]) err_q <= 1'b1;
        end
        if (abort) err_q <= 1'b1;
        if ((state_q == S_RD_WAIT) && lat_last) rdata_q <= avl.avl_mm_master_readdata_i;
      end
    end
  end

  assign avl.avl_mm_master_addr_o       = addr_q;
  assign avl.avl_mm_master_data_o       = data_q;
  assign avl.avl_mm_master_write_o      = wr_act;
  assign avl.avl_mm_master_read_o       = rd_act;
  assign avl.avl_mm_master_byteenable_o = x16_q;
  assign usr_ready_o = (state_q == S_IDLE);
  assign usr_done_o  = (state_q == S_DONE);
  assign usr_err_o   = (state_q == S_DONE) && err_q;
  assign usr_rdata_o = rdata_q;
  assign usr_irq_o   = irq_q;
endmodule
